// File: rtl/frame_stats_pkg.sv
// Shared types and width helpers for the frame statistics collector.
package frame_stats_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        RESULT = 2'd2
    } fs_state_t;

    // Bits needed to hold a count from 0 up to frame_len inclusive.
    function automatic int unsigned cnt_width(input int unsigned frame_len);
        return $clog2(frame_len + 1);
    endfunction

endpackage

// File: rtl/stats_accum.sv
// Running sum/min/max/over-threshold accumulators with clear and enable.
module stats_accum
    import frame_stats_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned THRESH = 1000,
    parameter int unsigned SUM_W  = 69,
    parameter int unsigned CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] sample,
    output logic [SUM_W-1:0]  sum_c,
    output logic [DATA_W-1:0] min_c,
    output logic [DATA_W-1:0] max_c,
    output logic [CNT_W-1:0]  over_c
);

    logic [SUM_W-1:0]  sum_q,  sum_d;
    logic [DATA_W-1:0] min_q,  min_d;
    logic [DATA_W-1:0] max_q,  max_d;
    logic [CNT_W-1:0]  over_q, over_d;

    // Values the accumulators take if the current sample is folded in.
    always_comb begin
        sum_c  = sum_q + SUM_W'(sample);
        min_c  = (sample < min_q) ? sample : min_q;
        max_c  = (sample > max_q) ? sample : max_q;
        over_c = over_q + CNT_W'(sample > DATA_W'(THRESH));
    end

    always_comb begin
        sum_d  = sum_q;
        min_d  = min_q;
        max_d  = max_q;
        over_d = over_q;
        if (clr) begin
            sum_d  = '0;
            min_d  = '1;
            max_d  = '0;
            over_d = '0;
        end else if (en) begin
            sum_d  = sum_c;
            min_d  = min_c;
            max_d  = max_c;
            over_d = over_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            min_q  <= '1;
            max_q  <= '0;
            over_q <= '0;
        end else begin
            sum_q  <= sum_d;
            min_q  <= min_d;
            max_q  <= max_d;
            over_q <= over_d;
        end
    end

endmodule

// File: rtl/frame_stats_collector.sv
// Pulls FRAME_LEN samples from the generator and presents sum/min/max/over-count
// on a valid/ready result port.
module frame_stats_collector
    import frame_stats_pkg::*;
#(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned FRAME_LEN = 16,
    parameter int unsigned THRESH    = 1000,
    parameter int unsigned SUM_W     = DATA_W + cnt_width(FRAME_LEN),
    parameter int unsigned CNT_W     = cnt_width(FRAME_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              next,
    input  logic [DATA_W-1:0] sample,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [SUM_W-1:0]  res_sum,
    output logic [DATA_W-1:0] res_min,
    output logic [DATA_W-1:0] res_max,
    output logic [CNT_W-1:0]  res_over
);

    fs_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              res_valid_q, res_valid_d;
    logic [SUM_W-1:0]  res_sum_q, res_sum_d;
    logic [DATA_W-1:0] res_min_q, res_min_d;
    logic [DATA_W-1:0] res_max_q, res_max_d;
    logic [CNT_W-1:0]  res_over_q, res_over_d;

    logic              acc_clr;
    logic              acc_en;
    logic [SUM_W-1:0]  sum_c;
    logic [DATA_W-1:0] min_c;
    logic [DATA_W-1:0] max_c;
    logic [CNT_W-1:0]  over_c;

    stats_accum #(
        .DATA_W (DATA_W),
        .THRESH (THRESH),
        .SUM_W  (SUM_W),
        .CNT_W  (CNT_W)
    ) u_accum (
        .clk    (clk),
        .rst    (rst),
        .clr    (acc_clr),
        .en     (acc_en),
        .sample (sample),
        .sum_c  (sum_c),
        .min_c  (min_c),
        .max_c  (max_c),
        .over_c (over_c)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;
        res_sum_d  = res_sum_q;
        res_min_d  = res_min_q;
        res_max_d  = res_max_q;
        res_over_d = res_over_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    acc_clr = 1'b1;
                end
            end
            RUN: begin
                acc_en = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
                // Last sample: publish the folded-in values directly.
                if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                    state_d    = RESULT;
                    res_sum_d  = sum_c;
                    res_min_d  = min_c;
                    res_max_d  = max_c;
                    res_over_d = over_c;
                end
            end
            RESULT: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d      = (state_d != IDLE);
        res_valid_d = (state_d == RESULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_min_q   <= '0;
            res_max_q   <= '0;
            res_over_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_min_q   <= res_min_d;
            res_max_q   <= res_max_d;
            res_over_q  <= res_over_d;
        end
    end

    assign next      = (state_q == RUN);
    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_min   = res_min_q;
    assign res_max   = res_max_q;
    assign res_over  = res_over_q;

endmodule

// File: doc/frame_stats_collector.md
# frame_stats_collector

Consumer stage for the test data generator: pulls a frame of `FRAME_LEN` samples over the generator's `next`/`out` interface, then computes the frame's sum, minimum, maximum and over-threshold count. It holds the result on a valid/ready output until the downstream checker takes it. A frame is one `start` request followed by `FRAME_LEN` consecutive sample fetches.

## Interface
Parameters:
- `DATA_W`, 64: sample width; matches the generator's `out`.
- `FRAME_LEN`, 16: samples per frame; must be at least 1.
- `THRESH`, 1000: samples strictly greater than this are counted as over-threshold.
- `SUM_W`, `DATA_W + $clog2(FRAME_LEN+1)`: accumulator width; cannot overflow.
- `CNT_W`, `$clog2(FRAME_LEN+1)`: width of the sample counter and the over-threshold count.

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous active-high reset.
- `start`, in, 1: request one frame; accepted only in IDLE.
- `next`, out, 1: advance pulse to the generator; high for each sample consumed.
- `sample`, in, `DATA_W`: generator `out`; unsigned.
- `busy`, out, 1: high in RUN and RESULT.
- `res_valid`, out, 1: result fields valid.
- `res_ready`, in, 1: downstream accepts the result.
- `res_sum`, out, `SUM_W`: unsigned sum of the frame.
- `res_min`, out, `DATA_W`: smallest sample in the frame.
- `res_max`, out, `DATA_W`: largest sample in the frame.
- `res_over`, out, `CNT_W`: number of samples with `sample > THRESH`.

## Operation
- The FSM has three states: IDLE, RUN and RESULT.
- IDLE to RUN: `start` is high at a clock edge. On that same edge the block clears the accumulators: sum=0, min=all-ones, max=0, over=0, count=0.
- RUN:
  - `next` is 1 and is a combinational decode of the state.
  - Each edge in RUN captures `sample` into the accumulators:
    - sum += sample
    - min = min(min, sample)
    - max = max(max, sample)
    - over += (sample > THRESH)
    - count += 1
  - The generator advances on the same edge, so the value captured is the one indexed before the advance.
- RUN to RESULT: on the edge that captures sample number `FRAME_LEN` (count == `FRAME_LEN`-1 before that edge). On that edge the final values are written into the result registers.
- RESULT: `res_valid`=1 and the result fields are stable.
  - If `res_valid && res_ready` at an edge, the FSM goes to IDLE.
  - If `res_ready` is low, the FSM stays in RESULT indefinitely.
- `start` is ignored in RUN and RESULT; it is not queued.
- All comparisons and the sum are unsigned.

## Timing
- Reset values: `next`=0, `busy`=0, `res_valid`=0, `res_sum`=0, `res_min`=0, `res_max`=0, `res_over`=0. State is IDLE.
- Reset takes priority over every other event. If `rst` is asserted mid-RUN, `next` drops in the cycle after the reset edge, and a partial frame is discarded and never presented.
- Latency: with `start` seen at edge E0, `next` is high from E0 to E0+`FRAME_LEN` (`FRAME_LEN` cycles), and `res_valid` rises after edge E0+`FRAME_LEN`.
- Minimum start-to-start period is `FRAME_LEN`+2 cycles, with `res_ready` held at 1.
- `res_ready` may be high before `res_valid` rises. The handshake then completes on the first RESULT cycle.
- `res_*` hold their values after the handshake until the next frame's RESULT entry. Only `res_valid` qualifies them.
- With `FRAME_LEN`=1, RUN lasts exactly one cycle.
- `sample` must be stable before each RUN edge. The generator's output is a registered lookup, which meets this.

## Structure
- Package `frame_stats_pkg` holds:
  - the state enum `fs_state_t` {IDLE, RUN, RESULT};
  - a width helper function for `SUM_W`/`CNT_W`.
- Sub-module `stats_accum` holds the datapath: sum, min, max and over-threshold registers, with `clr` and `en` inputs and combinational next-value outputs.
- The top level holds the FSM, the sample counter and the result registers.

## Test plan
- Reset, then hold `start`=0 for 10 cycles → `next`=0, `busy`=0, `res_valid`=0, all `res_*`=0.
- Generator sequence 65,75,85,95,105,115,4454,125,140,140,140,140,10,10,10,10; pulse `start`; `res_ready`=1 → exactly 16 `next` cycles; `res_valid` asserted; `res_sum`=5719, `res_min`=10, `res_max`=4454, `res_over`=1.
- Same frame with `res_ready`=0 for 20 cycles then 1 → `res_valid` held high and fields stable for all 20 cycles; return to IDLE one edge after `res_ready` rises.
- Pulse `start` during RUN and again during RESULT → no effect; exactly 16 `next` pulses; single result.
- Assert `rst` after the 5th `next` → `next`=0 in the following cycle; `res_valid` never rises; a new `start` yields a full 16-sample frame.
- All samples 0xFFFF_FFFF_FFFF_FFFF, `FRAME_LEN`=16 → `res_sum`=0xF_FFFF_FFFF_FFFF_FFF0 (68 bits, no overflow); `res_min`=`res_max`=all-ones; `res_over`=16.
